// File: rtl/async_fifo_pkg.sv
// Shared definitions for the asynchronous FIFO status blocks (read-side empty
// and write-side full generators).
package async_fifo_pkg;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned PTR_MAX_W   = 32;

    // Callers zero-extend narrower pointers and truncate the result. Leading
    // zeros do not change either conversion, so one function serves every
    // pointer width up to PTR_MAX_W.
    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/rd_empty_gen_if.sv
// Read-side status bundle. The consumer (master) drives the pointers, and the
// empty generator (slave) returns the status flags.
interface rd_empty_gen_if #(
    parameter int unsigned SIZE = 8
);
    logic [SIZE:0] wr_ptr_gray;
    logic [SIZE:0] rd_ptr;
    logic          rd_fire;
    logic          empty;
    logic          almost_empty;
    logic [SIZE:0] rd_level;
    logic          underflow;
    logic [SIZE:0] rd_ptr_gray;

    modport master (
        output wr_ptr_gray, rd_ptr, rd_fire,
        input  empty, almost_empty, rd_level, underflow, rd_ptr_gray
    );

    modport slave (
        input  wr_ptr_gray, rd_ptr, rd_fire,
        output empty, almost_empty, rd_level, underflow, rd_ptr_gray
    );
endinterface

// File: rtl/ptr_sync.sv
// N-stage flop synchroniser for Gray-coded pointers crossing clock domains.
// The stages are a plain shift chain with no logic between them.
module ptr_sync #(
    parameter int unsigned Width  = 9,
    parameter int unsigned Stages = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);
    logic [Width-1:0] sync_d [Stages];
    logic [Width-1:0] sync_q [Stages];

    always_comb begin
        sync_d[0] = d_i;
        for (int i = 1; i < Stages; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < Stages; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[Stages-1];
endmodule

// File: rtl/rd_empty_gen.sv
// Read-domain status generator. It compares the synchronised write pointer with
// the post-read pointer and produces registered empty, level and underflow status.
module rd_empty_gen
    import async_fifo_pkg::*;
#(
    parameter int unsigned SIZE      = 8,
    parameter int unsigned AE_THRESH = 2
) (
    input logic           rclk,
    input logic           rd_srst,
    rd_empty_gen_if.slave bus
);
    localparam int unsigned PtrW = SIZE + 1;
    typedef logic [PtrW-1:0] ptr_t;

    ptr_t wr_gray_sync;
    ptr_t wbin, rnext, lvl;

    logic empty_d, empty_q;
    logic almost_empty_d, almost_empty_q;
    logic underflow_d, underflow_q;
    ptr_t rd_level_d, rd_level_q;
    ptr_t rd_ptr_gray_d, rd_ptr_gray_q;

    ptr_sync #(
        .Width  (PtrW),
        .Stages (SYNC_STAGES)
    ) u_wr_ptr_sync (
        .clk_i (rclk),
        .rst_i (rd_srst),
        .d_i   (bus.wr_ptr_gray),
        .q_o   (wr_gray_sync)
    );

    // The extra MSB makes the modular difference give 0..2^SIZE across pointer wrap.
    always_comb begin
        wbin           = ptr_t'(gray2bin(PTR_MAX_W'(wr_gray_sync)));
        rnext          = bus.rd_ptr + ptr_t'(bus.rd_fire);
        lvl            = wbin - rnext;
        empty_d        = (lvl == '0);
        almost_empty_d = (lvl <= ptr_t'(AE_THRESH));
        rd_level_d     = lvl;
        rd_ptr_gray_d  = ptr_t'(bin2gray(PTR_MAX_W'(rnext)));
        underflow_d    = underflow_q | (bus.rd_fire & empty_q);
    end

    always_ff @(posedge rclk) begin
        if (rd_srst) begin
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            underflow_q    <= 1'b0;
            rd_level_q     <= '0;
            rd_ptr_gray_q  <= '0;
        end else begin
            empty_q        <= empty_d;
            almost_empty_q <= almost_empty_d;
            underflow_q    <= underflow_d;
            rd_level_q     <= rd_level_d;
            rd_ptr_gray_q  <= rd_ptr_gray_d;
        end
    end

    assign bus.empty        = empty_q;
    assign bus.almost_empty = almost_empty_q;
    assign bus.underflow    = underflow_q;
    assign bus.rd_level     = rd_level_q;
    assign bus.rd_ptr_gray  = rd_ptr_gray_q;
endmodule

// File: tb/tb_rd_empty_gen.sv
// Bench for rd_empty_gen with depth 8: directed scenarios, then a legal random
// producer/consumer run, all compared against a pointer-arithmetic model.
module tb_rd_empty_gen;
    localparam int unsigned SIZE  = 3;
    localparam int unsigned AE    = 2;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned MOD   = 16;

    logic rclk    = 1'b0;
    logic rd_srst = 1'b1;

    rd_empty_gen_if #(.SIZE(SIZE)) bus ();

    rd_empty_gen #(
        .SIZE      (SIZE),
        .AE_THRESH (AE)
    ) dut (
        .rclk    (rclk),
        .rd_srst (rd_srst),
        .bus     (bus)
    );

    always #5 rclk = ~rclk;

    int          n_vec = 0;
    int          n_err = 0;
    int unsigned w_bin = 0;
    int unsigned r_ptr = 0;
    bit          fire  = 1'b0;

    // Reference model: the write pointer is seen two edges late, and status is
    // registered one edge after that.
    int unsigned m_seen [2] = '{0, 0};
    bit          m_empty = 1'b1;
    bit          m_ae    = 1'b1;
    bit          m_uf    = 1'b0;
    int unsigned m_level = 0;
    int unsigned m_gray  = 0;

    function automatic logic [3:0] to_gray(input int unsigned v);
        return 4'(v ^ (v >> 1));
    endfunction

    always @(posedge rclk) begin
        int unsigned rnext;
        int unsigned lvl;
        if (rd_srst) begin
            m_seen  = '{0, 0};
            m_empty = 1'b1;
            m_ae    = 1'b1;
            m_uf    = 1'b0;
            m_level = 0;
            m_gray  = 0;
        end else begin
            rnext = (r_ptr + int'(fire)) % MOD;
            lvl   = (m_seen[1] + MOD - rnext) % MOD;
            if (fire && m_empty) m_uf = 1'b1;
            if (lvl > DEPTH && !m_uf) begin
                n_err++;
                $display("FAIL level_range: model level %0d exceeds depth %0d", lvl, DEPTH);
            end
            m_empty   = (lvl == 0);
            m_ae      = (lvl <= AE);
            m_level   = lvl;
            m_gray    = int'(to_gray(rnext));
            m_seen[1] = m_seen[0];
            m_seen[0] = w_bin;
        end
    end

    // Inputs change on the falling edge; outputs are sampled on the next falling edge.
    task automatic step(input bit rst, input int unsigned w, input int unsigned r, input bit f);
        rd_srst         = rst;
        w_bin           = w % MOD;
        r_ptr           = r % MOD;
        fire            = f;
        bus.wr_ptr_gray = to_gray(w_bin);
        bus.rd_ptr      = 4'(r_ptr);
        bus.rd_fire     = f;
        @(posedge rclk);
        @(negedge rclk);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            step(c < 2, (c < 2) ? 4 : 0, 0, 1'b0);
            n_vec++;
            if (bus.empty !== 1'b1) begin
                n_err++;
                $display("FAIL reset_empty c=%0d: got %b want 1", c, bus.empty);
            end
            n_vec++;
            if (bus.almost_empty !== 1'b1) begin
                n_err++;
                $display("FAIL reset_ae c=%0d: got %b want 1", c, bus.almost_empty);
            end
            n_vec++;
            if (bus.rd_level !== 4'd0) begin
                n_err++;
                $display("FAIL reset_level c=%0d: got %0d want 0", c, bus.rd_level);
            end
            n_vec++;
            if (bus.underflow !== 1'b0 || bus.rd_ptr_gray !== 4'd0) begin
                n_err++;
                $display("FAIL reset_uf_gray c=%0d: got uf=%b gray=%h want 0/0", c, bus.underflow,
                         bus.rd_ptr_gray);
            end
        end
    endtask

    task automatic test_sync_latency();
        bit want_empty;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1, 0, 1'b0);
            want_empty = (k < 2);
            n_vec++;
            if (bus.empty !== want_empty || bus.empty !== m_empty) begin
                n_err++;
                $display("FAIL sync_latency edge N+%0d: got empty=%b want %b", k, bus.empty,
                         want_empty);
            end
        end
        n_vec++;
        if (bus.rd_level !== 4'd1) begin
            n_err++;
            $display("FAIL sync_level: got %0d want 1", bus.rd_level);
        end
    endtask

    task automatic test_drain();
        logic [3:0] prev_gray;
        int unsigned want;
        for (int k = 0; k < 3; k++) step(1'b0, 5, 0, 1'b0);
        n_vec++;
        if (bus.rd_level !== 4'd5) begin
            n_err++;
            $display("FAIL drain_start: got level %0d want 5", bus.rd_level);
        end
        prev_gray = bus.rd_ptr_gray;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 5, k, 1'b1);
            want = 4 - k;
            n_vec++;
            if (bus.rd_level !== 4'(want) || bus.almost_empty !== (want <= AE) ||
                bus.empty !== (want == 0)) begin
                n_err++;
                $display("FAIL drain k=%0d: got level=%0d ae=%b empty=%b want %0d/%b/%b", k,
                         bus.rd_level, bus.almost_empty, bus.empty, want, want <= AE, want == 0);
            end
            n_vec++;
            if ($countones(bus.rd_ptr_gray ^ prev_gray) > 1) begin
                n_err++;
                $display("FAIL drain_gray_step: got %h after %h want <=1 bit change",
                         bus.rd_ptr_gray, prev_gray);
            end
            prev_gray = bus.rd_ptr_gray;
        end
        step(1'b0, 5, 5, 1'b0);
    endtask

    task automatic test_full_wrap();
        step(1'b0, 5, 0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 8, 0, 1'b0);
        n_vec++;
        if (bus.rd_level !== 4'd8 || bus.empty !== 1'b0 || bus.almost_empty !== 1'b0) begin
            n_err++;
            $display("FAIL full: got level=%0d empty=%b ae=%b want 8/0/0", bus.rd_level,
                     bus.empty, bus.almost_empty);
        end
        for (int k = 0; k < 3; k++) step(1'b0, 2, 0, 1'b0);
        step(1'b0, 2, 14, 1'b0);
        n_vec++;
        if (bus.rd_level !== 4'd4 || int'(bus.rd_level) != m_level) begin
            n_err++;
            $display("FAIL wrap_level: got %0d want 4", bus.rd_level);
        end
        for (int k = 0; k < 3; k++) step(1'b0, 0, 14, 1'b0);
        step(1'b0, 0, 15, 1'b1);
        n_vec++;
        if (bus.empty !== 1'b1 || bus.rd_ptr_gray !== 4'd0) begin
            n_err++;
            $display("FAIL wrap_empty: got empty=%b gray=%h want 1/0", bus.empty, bus.rd_ptr_gray);
        end
    endtask

    task automatic test_simultaneous();
        for (int k = 0; k < 3; k++) step(1'b0, 3, 0, 1'b0);
        step(1'b0, 4, 0, 1'b0);
        step(1'b0, 4, 0, 1'b0);
        step(1'b0, 4, 0, 1'b1);
        n_vec++;
        if (bus.rd_level !== 4'd3 || bus.empty !== 1'b0) begin
            n_err++;
            $display("FAIL simul_rw: got level=%0d empty=%b want 3/0", bus.rd_level, bus.empty);
        end
        step(1'b0, 4, 1, 1'b0);
        n_vec++;
        if (bus.rd_level !== 4'd3 || bus.empty !== 1'b0) begin
            n_err++;
            $display("FAIL simul_after: got level=%0d empty=%b want 3/0", bus.rd_level, bus.empty);
        end
    endtask

    task automatic test_underflow();
        step(1'b0, 4, 4, 1'b0);
        step(1'b0, 4, 4, 1'b1);
        n_vec++;
        if (bus.underflow !== 1'b1) begin
            n_err++;
            $display("FAIL underflow_set: got %b want 1", bus.underflow);
        end
        for (int w = 5; w < 8; w++) begin
            step(1'b0, w, 4, 1'b0);
            n_vec++;
            if (bus.underflow !== 1'b1) begin
                n_err++;
                $display("FAIL underflow_sticky w=%0d: got %b want 1", w, bus.underflow);
            end
        end
        step(1'b1, 7, 4, 1'b0);
        n_vec++;
        if (bus.underflow !== 1'b0 || bus.empty !== 1'b1 || bus.rd_level !== 4'd0) begin
            n_err++;
            $display("FAIL underflow_clear: got uf=%b empty=%b level=%0d want 0/1/0",
                     bus.underflow, bus.empty, bus.rd_level);
        end
        for (int k = 0; k < 3; k++) step(1'b0, 0, 0, 1'b0);
        n_vec++;
        if (bus.underflow !== 1'b0) begin
            n_err++;
            $display("FAIL underflow_after_rst: got %b want 0", bus.underflow);
        end
    endtask

    task automatic test_random();
        int unsigned w_tot = 0;
        int unsigned r_tot = 0;
        int unsigned nw;
        bit          f;
        logic [3:0]  prev_gray;
        prev_gray = bus.rd_ptr_gray;
        for (int i = 0; i < 300; i++) begin
            nw = w_tot;
            if ((w_tot - r_tot) < DEPTH && $urandom_range(0, 1) == 1) nw = w_tot + 1;
            f = !m_empty && ($urandom_range(0, 2) != 0);
            step(1'b0, nw, r_tot, f);
            w_tot = nw;
            r_tot = r_tot + int'(f);
            n_vec++;
            if (bus.empty !== m_empty || bus.almost_empty !== m_ae || bus.underflow !== m_uf ||
                int'(bus.rd_level) != m_level || int'(bus.rd_ptr_gray) != m_gray) begin
                n_err++;
                $display("FAIL random i=%0d: got e=%b ae=%b uf=%b lvl=%0d g=%h want %b/%b/%b/%0d/%h",
                         i, bus.empty, bus.almost_empty, bus.underflow, bus.rd_level,
                         bus.rd_ptr_gray, m_empty, m_ae, m_uf, m_level, m_gray);
            end
            n_vec++;
            if ($countones(bus.rd_ptr_gray ^ prev_gray) > 1) begin
                n_err++;
                $display("FAIL random_gray_step i=%0d: got %h after %h want <=1 bit change", i,
                         bus.rd_ptr_gray, prev_gray);
            end
            prev_gray = bus.rd_ptr_gray;
        end
    endtask

    initial begin
        bus.wr_ptr_gray = '0;
        bus.rd_ptr      = '0;
        bus.rd_fire     = 1'b0;
        @(negedge rclk);
        test_reset();
        test_sync_latency();
        test_drain();
        test_full_wrap();
        test_simultaneous();
        test_underflow();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
